cam_subarray_seq: RTL
=====================

# cam_subarray_seq

Command sequencer that drives one CAM subarray through its port-level protocol. It accepts high-level commands over a valid/ready interface: multi-digit key search, direct write, and masked update. It expands each command into the per-cycle `operation_mode`, `cmp_addr`, `cmp_data`, `acc_en` and `write_done` sequence the subarray expects. It returns the captured `tag_out` over a valid/ready response interface, and sits between the array scheduler and `CAM_Subarray_Exp`.

## Interface
Parameters:
- `NDIG`, 4: 2-bit key digits per search, legal range 1..16.
- `TAG_W`, 16: tag/data width, matching the subarray.
- `COL_W`, 5: column field width of `cmp_addr`.

Ports:
- `CLK`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1; `cmd_ready`  out  1: command handshake.
- `cmd_op`  in  2: 00 WRITE, 01 UPDATE, 10 SEARCH, 11 UPDATE_TAG.
- `cmd_grp`  in  5: upper field of `cmp_addr`.
- `cmd_col`  in  COL_W: first search column.
- `cmd_key`  in  2*NDIG: digit i is `[2i+1:2i]`.
- `cmd_data`, `cmd_mask`  in  TAG_W: write data and update mask.
- `cmd_ppg_addr`  in  4; `cmd_ppg_data`  in  2: passed to `ppg_addr`/`ppg_data`.
- `rsp_valid`  out  1; `rsp_ready`  in  1: response handshake.
- `rsp_tag`  out  TAG_W: captured tag (0 for writes).
- `rsp_err`  out  1: illegal command.
- Subarray side, outputs:
  - `data_in`  out  TAG_W
  - `update_signal`  out  1
  - `cmp_addr`  out  10
  - `ppg_addr`  out  4
  - `cmp_data`  out  2
  - `ppg_data`  out  2
  - `tag_in`  out  TAG_W
  - `addr_select`  out  1
  - `operation_mode`  out  3
  - `chip_enable`  out  1
  - `acc_en`  out  1
  - `write_done`  out  1
- Subarray side, input: `tag_out`  in  TAG_W.

## Operation
- FSM states: IDLE, SRCH, WAIT, WR, WDONE, RESP.
- IDLE:
  - `cmd_ready`=1; all subarray outputs 0.
  - On `cmd_valid`, latch every `cmd_*` field, drop `cmd_ready`, then branch on `cmd_op`.
- SEARCH, NDIG cycles in SRCH; step i = 0..NDIG-1:
  - `chip_enable`=1, `operation_mode`=010.
  - `cmp_addr`={grp, (col+i) mod 2^COL_W}; the column wraps 31→0.
  - `cmp_data`=digit i; `acc_en`=(i≠0).
  - Then one WAIT cycle (`chip_enable`=1, `operation_mode`=010, `acc_en`=0, `cmp_data` held). Register `tag_out` into `rsp_tag` at the end of WAIT, then go to RESP.
- WRITE: WR for one cycle with `chip_enable`=1, `operation_mode`=000, `addr_select`=1, `data_in`=data. Then WDONE for one cycle with `write_done`=1 and everything else 0, then RESP with `rsp_tag`=0.
- UPDATE: same path as WRITE, except WR drives `operation_mode`=001, `addr_select`=0, `update_signal`=1, `tag_in`=mask.
- `ppg_addr` and `ppg_data` are driven from the latched fields during SRCH/WR/WAIT and are 0 otherwise.
- RESP: hold `rsp_valid`, `rsp_tag` and `rsp_err` stable until `rsp_ready`, then return to IDLE.
- `cmd_valid` while not in IDLE is ignored; `cmd_ready` is 0.

## Timing
- Reset values: every output 0, except that `cmd_ready` becomes 1 on the first cycle after `rst` deasserts; state is IDLE.
- Reset mid-operation: IDLE at the next edge, all subarray outputs 0, pending response discarded, no `write_done` pulse.
- SEARCH: `rsp_valid` rises NDIG+1 cycles after the accept edge. For NDIG=1, `acc_en` is never asserted.
- WRITE/UPDATE: `rsp_valid` rises 2 cycles after the accept edge.
- Earliest back-to-back accept: the cycle after the `rsp_valid`&`rsp_ready` edge.
- `write_done` is a single-cycle pulse, exactly once per WRITE/UPDATE.

## Configuration
- `CAM_SEQ_TAG_CHAIN_EN` defined:
  - UPDATE_TAG executes as UPDATE with `tag_in` = last successfully returned SEARCH `rsp_tag`, held in a chain register; `cmd_mask` is ignored.
  - The chain register resets to 0.
- Undefined:
  - UPDATE_TAG produces no subarray activity.
  - It goes directly to RESP with `rsp_err`=1 and `rsp_tag`=0; `rsp_valid` rises 1 cycle after accept.
  - No chain register exists.

## Structure
- Package `cam_seq_pkg` holds:
  - opcode localparams
  - FSM state enum
  - subarray mode encodings (MODE_WRITE=000, MODE_UPDATE=001, MODE_SEARCH=010)
  - `CMP_ADDR_W`=10
- One sub-module, `cam_key_shifter`: loads `cmd_key` and shifts it right by 2 bits per SRCH step, presenting the current digit, step index and last-step flag.

## Test plan
- WRITE with data=FFFF, grp=1 → one cycle of mode 000, `addr_select`=1, `data_in`=FFFF; `write_done` pulse next cycle; `rsp_tag`=0, `rsp_err`=0 at accept+2.
- SEARCH with NDIG=4, col=30, key=8'b00_01_10_01, grp=1 → `cmp_addr` sequence 0x03E, 0x03F, 0x020, 0x021; `cmp_data` sequence 01, 10, 01, 00; `acc_en` sequence 0, 1, 1, 1; `rsp_tag` equals `tag_out` sampled at end of WAIT.
- `rsp_ready` held low for 5 cycles → `rsp_valid`/`rsp_tag` stable throughout, `cmd_ready`=0, a concurrent `cmd_valid` is not accepted.
- `rst` low during SRCH step 2 → all outputs 0 next cycle, no response, next command executes normally.
- UPDATE_TAG after a SEARCH returning AAAA:
  - with `CAM_SEQ_TAG_CHAIN_EN` → mode 001, `tag_in`=AAAA, `update_signal`=1.
  - without → no activity, `rsp_err`=1 at accept+1.

Source files
------------

// File: rtl/cam_seq_pkg.sv
// rtl/cam_seq_pkg.sv - shared opcodes, subarray mode encodings and FSM states for the CAM sequencer
package cam_seq_pkg;

  localparam logic [1:0] OP_WRITE      = 2'b00;
  localparam logic [1:0] OP_UPDATE     = 2'b01;
  localparam logic [1:0] OP_SEARCH     = 2'b10;
  localparam logic [1:0] OP_UPDATE_TAG = 2'b11;

  localparam logic [2:0] MODE_WRITE  = 3'b000;
  localparam logic [2:0] MODE_UPDATE = 3'b001;
  localparam logic [2:0] MODE_SEARCH = 3'b010;

  localparam int CMP_ADDR_W = 10;
  localparam int GRP_W      = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SRCH  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WR    = 3'd3,
    ST_WDONE = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

endpackage

// File: rtl/cam_key_shifter.sv
// rtl/cam_key_shifter.sv - search key digit shifter presenting current digit, step index and last-step flag
module cam_key_shifter #(
  parameter int NDIG = 4
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              i_load,
  input  logic [2*NDIG-1:0] i_key,
  input  logic              i_shift,
  output logic [1:0]        o_digit,
  output logic [3:0]        o_step,
  output logic              o_last
);

  logic [2*NDIG-1:0] r_key;
  logic [3:0]        r_step;

  // Load the key on accept; advance one digit per search step, freezing on the
  // last step so the final digit stays visible through the settle cycle.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      r_key  <= '0;
      r_step <= '0;
    end else if (i_load) begin
      r_key  <= i_key;
      r_step <= '0;
    end else if (i_shift && !o_last) begin
      r_key  <= r_key >> 2;
      r_step <= r_step + 4'd1;
    end
  end

  assign o_digit = r_key[1:0];
  assign o_step  = r_step;
  assign o_last  = (r_step == 4'(NDIG - 1));

endmodule

// File: rtl/cam_subarray_seq.sv
// rtl/cam_subarray_seq.sv - CAM subarray command sequencer; optional tag chaining via CAM_SEQ_TAG_CHAIN_EN
module cam_subarray_seq
  import cam_seq_pkg::*;
#(
  parameter int NDIG  = 4,
  parameter int TAG_W = 16,
  parameter int COL_W = 5
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [GRP_W-1:0]      cmd_grp,
  input  logic [COL_W-1:0]      cmd_col,
  input  logic [2*NDIG-1:0]     cmd_key,
  input  logic [TAG_W-1:0]      cmd_data,
  input  logic [TAG_W-1:0]      cmd_mask,
  input  logic [3:0]            cmd_ppg_addr,
  input  logic [1:0]            cmd_ppg_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [TAG_W-1:0]      rsp_tag,
  output logic                  rsp_err,
  output logic [TAG_W-1:0]      data_in,
  output logic                  update_signal,
  output logic [CMP_ADDR_W-1:0] cmp_addr,
  output logic [3:0]            ppg_addr,
  output logic [1:0]            cmp_data,
  output logic [1:0]            ppg_data,
  output logic [TAG_W-1:0]      tag_in,
  output logic                  addr_select,
  output logic [2:0]            operation_mode,
  output logic                  chip_enable,
  output logic                  acc_en,
  output logic                  write_done,
  input  logic [TAG_W-1:0]      tag_out
);

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_op;
  logic [GRP_W-1:0]   r_grp;
  logic [COL_W-1:0]   r_col;
  logic [TAG_W-1:0]   r_data;
  logic [TAG_W-1:0]   r_mask;
  logic [3:0]         r_ppg_addr;
  logic [1:0]         r_ppg_data;
  logic [TAG_W-1:0]   r_rsp_tag;
  logic               r_rsp_err;
  logic               w_accept;
  logic [1:0]         w_digit;
  logic [3:0]         w_step;
  logic               w_last;
  logic [COL_W-1:0]   w_col;
  logic [TAG_W-1:0]   w_upd_tag;

  assign w_accept = cmd_valid && cmd_ready;
  assign w_col    = r_col + COL_W'(w_step);

  cam_key_shifter #(.NDIG(NDIG)) u_key_shifter (
    .CLK     (CLK),
    .rst     (rst),
    .i_load  (w_accept),
    .i_key   (cmd_key),
    .i_shift (r_state == ST_SRCH),
    .o_digit (w_digit),
    .o_step  (w_step),
    .o_last  (w_last)
  );

`ifdef CAM_SEQ_TAG_CHAIN_EN
  logic [TAG_W-1:0] r_chain;

  // Remember the tag of the last search response the scheduler actually took.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      r_chain <= '0;
    end else if (r_state == ST_RESP && rsp_ready && r_op == OP_SEARCH) begin
      r_chain <= r_rsp_tag;
    end
  end

  assign w_upd_tag = (cmd_op == OP_UPDATE_TAG) ? r_chain : cmd_mask;
`else
  assign w_upd_tag = cmd_mask;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_SEARCH:     w_next = ST_SRCH;
`ifdef CAM_SEQ_TAG_CHAIN_EN
            OP_UPDATE_TAG: w_next = ST_WR;
`else
            OP_UPDATE_TAG: w_next = ST_RESP;
`endif
            default:       w_next = ST_WR;
          endcase
        end
      end
      ST_SRCH:  if (w_last) w_next = ST_WAIT;
      ST_WAIT:  w_next = ST_RESP;
      ST_WR:    w_next = ST_WDONE;
      ST_WDONE: w_next = ST_RESP;
      ST_RESP:  if (rsp_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Command field latch and response capture.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      r_op       <= '0;
      r_grp      <= '0;
      r_col      <= '0;
      r_data     <= '0;
      r_mask     <= '0;
      r_ppg_addr <= '0;
      r_ppg_data <= '0;
      r_rsp_tag  <= '0;
      r_rsp_err  <= 1'b0;
    end else if (w_accept) begin
      r_op       <= cmd_op;
      r_grp      <= cmd_grp;
      r_col      <= cmd_col;
      r_data     <= cmd_data;
      r_mask     <= w_upd_tag;
      r_ppg_addr <= cmd_ppg_addr;
      r_ppg_data <= cmd_ppg_data;
      r_rsp_tag  <= '0;
`ifdef CAM_SEQ_TAG_CHAIN_EN
      r_rsp_err  <= 1'b0;
`else
      r_rsp_err  <= (cmd_op == OP_UPDATE_TAG);
`endif
    end else if (r_state == ST_WAIT) begin
      r_rsp_tag  <= tag_out;
    end
  end

  // Per-state drive of the handshake and subarray pins.
  always_comb begin
    cmd_ready      = 1'b0;
    rsp_valid      = 1'b0;
    rsp_tag        = '0;
    rsp_err        = 1'b0;
    data_in        = '0;
    update_signal  = 1'b0;
    cmp_addr       = '0;
    ppg_addr       = '0;
    cmp_data       = '0;
    ppg_data       = '0;
    tag_in         = '0;
    addr_select    = 1'b0;
    operation_mode = MODE_WRITE;
    chip_enable    = 1'b0;
    acc_en         = 1'b0;
    write_done     = 1'b0;
    case (r_state)
      ST_IDLE: cmd_ready = rst;
      ST_SRCH, ST_WAIT: begin
        chip_enable    = 1'b1;
        operation_mode = MODE_SEARCH;
        cmp_addr       = CMP_ADDR_W'({r_grp, w_col});
        cmp_data       = w_digit;
        acc_en         = (r_state == ST_SRCH) && (w_step != 4'd0);
        ppg_addr       = r_ppg_addr;
        ppg_data       = r_ppg_data;
      end
      ST_WR: begin
        chip_enable = 1'b1;
        data_in     = r_data;
        ppg_addr    = r_ppg_addr;
        ppg_data    = r_ppg_data;
        if (r_op == OP_WRITE) begin
          operation_mode = MODE_WRITE;
          addr_select    = 1'b1;
        end else begin
          operation_mode = MODE_UPDATE;
          update_signal  = 1'b1;
          tag_in         = r_mask;
        end
      end
      ST_WDONE: write_done = 1'b1;
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_tag   = r_rsp_tag;
        rsp_err   = r_rsp_err;
      end
      default: ;
    endcase
  end

endmodule
